// File: rtl/ps_input_arbiter_pkg.sv
// ps_input_arbiter_pkg
//   Constants and types shared by the PS-stage input arbiter slice.
//   PKT_W           : packet width; must match the PS stage input packet width
//   CNT_W           : width of the completed-packet counter
//   SYNC_STAGES_DEF : default depth of the Ack_in synchronizer
//   state_e         : arbiter FSM state encoding (2 bits)
//   rr_pick()       : round-robin grant decision for the two input ports
package ps_input_arbiter_pkg;

  localparam int PKT_W           = 52;
  localparam int CNT_W           = 16;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RTZ  = 2'd2
  } state_e;

  // Returns the port to grant. On a tie the port that did not win last time
  // is chosen; with a single eligible port that port is returned. The result
  // is meaningless when neither port is eligible.
  function automatic logic rr_pick(input logic elig0, input logic elig1,
                                   input logic last);
    if (elig0 && elig1) begin
      return ~last;
    end
    return elig1;
  endfunction

endpackage

// File: rtl/ps_input_arbiter_if.sv
// ps_input_arbiter_if
//   Bundles the two clocked 4-phase input channels and the 4-phase output
//   channel toward the self-timed PS lookup stage.
//   Send_in0/1   : source requests (level, 4-phase, synchronous to CLK)
//   PACKET_IN0/1 : source packets, stable while the matching Send_in is high
//   Ack_out0/1   : acknowledges back to the sources
//   Send_out     : request to the PS stage Send_in
//   PACKET_OUT   : registered packet to the PS stage PACKET_IN
//   Ack_in       : PS stage Ack_out, asynchronous to CLK
//   Pkt_cnt      : packets completed toward the PS stage (wraps)
//   modport slave  : the arbiter side
//   modport master : the side that drives sources and the PS stage Ack
interface ps_input_arbiter_if
  import ps_input_arbiter_pkg::*;
#(
  parameter int PW = PKT_W
);

  logic             Send_in0;
  logic [PW-1:0]    PACKET_IN0;
  logic             Ack_out0;
  logic             Send_in1;
  logic [PW-1:0]    PACKET_IN1;
  logic             Ack_out1;
  logic             Send_out;
  logic [PW-1:0]    PACKET_OUT;
  logic             Ack_in;
  logic [CNT_W-1:0] Pkt_cnt;

  modport slave (
    input  Send_in0, PACKET_IN0, Send_in1, PACKET_IN1, Ack_in,
    output Ack_out0, Ack_out1, Send_out, PACKET_OUT, Pkt_cnt
  );

  modport master (
    output Send_in0, PACKET_IN0, Send_in1, PACKET_IN1, Ack_in,
    input  Ack_out0, Ack_out1, Send_out, PACKET_OUT, Pkt_cnt
  );

endinterface

// File: rtl/ps_input_arbiter_ack_sync.sv
// ack_sync
//   SYNC_STAGES-deep flop chain bringing the self-timed PS stage Ack back
//   into the CLK domain. MR clears every stage so a reset mid-handshake
//   cannot leave a stale Ack in flight. SYNC_STAGES must be at least 2.
//   CLK      : clock, rising edge
//   MR       : synchronous active-high clear
//   async_in : asynchronous Ack from the PS stage
//   sync_out : synchronized Ack (last stage of the chain)
module ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic MR,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CLK) begin
    if (MR) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps_input_arbiter.sv
// ps_input_arbiter
//   Round-robin merge of two clocked 4-phase packet sources into the single
//   4-phase input channel of the self-timed PS lookup stage. One packet is
//   held in PACKET_OUT from its grant until the next grant. All outputs come
//   straight from flops.
//   CLK : clock, rising edge
//   MR  : master reset, synchronous, active-high
//   bus : ps_input_arbiter_if.slave (source channels, PS channel, Pkt_cnt)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no packet toward PS stage; grant an eligible port if any
//   SEND  | Send_out high, waiting for the synchronized Ack to rise
//   RTZ   | Send_out low, waiting for the synchronized Ack to fall
module ps_input_arbiter
  import ps_input_arbiter_pkg::*;
#(
  parameter int PW          = PKT_W,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic               CLK,
  input logic               MR,
  ps_input_arbiter_if.slave bus
);

  state_e           state_q;
  state_e           state_d;
  logic             send_out_q;
  logic             send_out_d;
  logic [1:0]       ack_out_q;
  logic [1:0]       ack_out_d;
  logic [PW-1:0]    packet_q;
  logic [PW-1:0]    packet_d;
  logic             last_q;
  logic             last_d;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic             cnt_inc;
  logic             ack_s;
  logic             elig0;
  logic             elig1;
  logic             grant_port;

  ack_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .CLK     (CLK),
    .MR      (MR),
    .async_in(bus.Ack_in),
    .sync_out(ack_s)
  );

  // Eligibility uses the registered acknowledge, so a port released on this
  // edge only competes from the next cycle on.
  assign elig0      = bus.Send_in0 & ~ack_out_q[0];
  assign elig1      = bus.Send_in1 & ~ack_out_q[1];
  assign grant_port = rr_pick(elig0, elig1, last_q);

  // State register
  always_ff @(posedge CLK) begin
    if (MR) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (elig0 | elig1) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ack_s) begin
          state_d = ST_RTZ;
        end
      end
      ST_RTZ: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    send_out_d = send_out_q;
    packet_d   = packet_q;
    last_d     = last_q;
    cnt_inc    = 1'b0;
    // Input-side release runs independently of the FSM: an acknowledged
    // port drops its Ack one edge after its Send is seen low.
    ack_out_d[0] = ack_out_q[0] & bus.Send_in0;
    ack_out_d[1] = ack_out_q[1] & bus.Send_in1;
    case (state_q)
      ST_IDLE: begin
        send_out_d = 1'b0;
        if (elig0 | elig1) begin
          send_out_d            = 1'b1;
          last_d                = grant_port;
          ack_out_d[grant_port] = 1'b1;
          packet_d              = grant_port ? bus.PACKET_IN1 : bus.PACKET_IN0;
        end
      end
      ST_SEND: begin
        if (ack_s) begin
          send_out_d = 1'b0;
        end
      end
      ST_RTZ: begin
        send_out_d = 1'b0;
        if (!ack_s) begin
          cnt_inc = 1'b1;
        end
      end
      default: send_out_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      send_out_q <= 1'b0;
      ack_out_q  <= 2'b00;
      packet_q   <= '0;
      // last starts at port 1 so port 0 wins the first tie after reset
      last_q     <= 1'b1;
    end else begin
      send_out_q <= send_out_d;
      ack_out_q  <= ack_out_d;
      packet_q   <= packet_d;
      last_q     <= last_d;
    end
  end

  // Counts a packet when the PS stage handshake has fully returned to zero.
  always_ff @(posedge CLK) begin
    if (MR) begin
      pkt_cnt_q <= '0;
    end else if (cnt_inc) begin
      pkt_cnt_q <= pkt_cnt_q + 1'b1;
    end
  end

  assign bus.Send_out   = send_out_q;
  assign bus.Ack_out0   = ack_out_q[0];
  assign bus.Ack_out1   = ack_out_q[1];
  assign bus.PACKET_OUT = packet_q;
  assign bus.Pkt_cnt    = pkt_cnt_q;

endmodule
